id_stage_piped: RTL
===================

// Module: id_stage_piped
// PURPOSE
//  Parametrised ARM decode stage with integrated ID/EX pipeline register, bypassing register
//  file and built-in hazard detection. Sits between the IF/ID register and EXE stage.
//  Outputs are registered: 1-cycle latency. Hazard unit and ID/EX register are absorbed here.
//  Forwarding-aware: with FORWARD_EN it stalls only on load-use.
// PARAMETERS
//  N          32  data/PC width
//  FORWARD_EN 0   1: stall only on load-use (EXE load writing a used source); 0: stall on any EXE/MEM RAW
//  WB_BYPASS  1   1: same-cycle WB write is visible to reads (write-through); 0: read old value
// PORTS
//  clk              in  1   clock, rising edge
//  rst              in  1   asynchronous, active-low reset
//  instructionIn    in  N   instruction from IF/ID
//  PCIn             in  N   PC+4 from IF/ID
//  validIn          in  1   IF/ID holds a real instruction
//  statusIn         in  4   NZCV from status register
//  flushIn          in  1   branch taken in EXE; kill the instruction being decoded
//  WB_ENIn,WB_DestIn,WB_ValueIn  in 1,4,N  register-file write port
//  EXE_WB_ENIn,EXE_MEM_R_ENIn,EXE_DestIn  in 1,1,4  instruction currently in EXE
//  MEM_WB_ENIn,MEM_DestIn        in 1,4  instruction currently in MEM
//  HazardOut        out 1   combinational stall request to IF (freeze PC and IF/ID)
//  validOut         out 1   ID/EX holds a real instruction
//  PCOut,Val_RnOut,Val_RmOut     out N   registered PC and operands
//  SrcRnOut,SrcRmOut,DestOut     out 4   registered source/dest register numbers (for forwarding)
//  EXE_CMDOut       out 4   registered ALU command
//  SOut,BOut,MEM_W_ENOut,MEM_R_ENOut,WB_ENOut,IOut,Two_srcOut  out 1  registered controls
//  shiftOperandOut  out 12  registered instr[11:0];  Imm24Out  out 24  registered instr[23:0]
// BEHAVIOUR
//  - Fields: cond[31:28] mode[27:26] I[25] opcode[24:21] S[20] Rn[19:16] Rd[15:12] Rm[3:0].
//  - Decode as existing ARM control unit: mode 00 data-proc, 01 LDR(S=1)/STR(S=0), 10 branch.
//  - Second read address = Rd when STR, else Rm. Two_src = ~I | STR.
//  - Rn used unless branch or opcode MOV(1101)/MVN(1111); second source used iff Two_src.
//  - Hazard (validIn & ~flushIn & used source s):
//    FORWARD_EN=0: (EXE_WB_ENIn & s==EXE_DestIn) | (MEM_WB_ENIn & s==MEM_DestIn)
//    FORWARD_EN=1: EXE_MEM_R_ENIn & EXE_WB_ENIn & s==EXE_DestIn. HazardOut independent of cond.
//  - Condition check vs statusIn (EQ..AL, 1111 = never). Fail -> bubble.
//  - Each rising clk the ID/EX register loads one of (priority order):
//    flushIn -> bubble; HazardOut -> bubble; ~validIn or cond fail -> bubble; else decoded fields.
//  - Bubble: validOut, WB_EN, MEM_R/W, B, S, EXE_CMD = 0; data fields may load, are don't-care.
//  - Register file: 16 x N, written at rising clk when WB_ENIn. WB_BYPASS=1: read of WB_DestIn
//    in the write cycle returns WB_ValueIn. Writes proceed during stall/flush.
//  - rst low (any time, async): all ID/EX outputs 0, all registers 0, validOut=0. Mid-stall
//    reset drops the held bubble; first edge after release loads normally.
//  - Back-to-back hazard: bubble repeats each cycle until hazard clears; no instruction lost
//    because IF holds. flushIn with hazard: flush wins, HazardOut still reported.
// STRUCTURE
//  - Shared package: EXE_CMD codes (MOV,MVN,ADD,ADC,SUB,SBC,AND,ORR,EOR,CMP,TST,LDR,STR),
//    mode codes, cond codes, opcode constants MOV/MVN.
//  - Sub-module regfile_bypass (16xN, 2R/1W, WB_BYPASS param, async active-low reset).
//  - Decode, cond check, hazard logic and ID/EX register inline.
// TESTING
//  - Reset: rst low mid-stream -> all outputs 0 immediately; after release, ADD R1,R2,R3 decodes next edge.
//  - ADD R1,R2,R3 (AL), R2=5,R3=7 -> next cycle Val_Rn=5, Val_Rm=7, WB_EN=1, EXE_CMD=ADD, validOut=1.
//  - STR R4,[R5] with EXE_WB_EN=1, EXE_Dest=4, FORWARD_EN=0 -> HazardOut=1, bubble; clear -> MEM_W_EN=1, Val_Rm=R4.
//  - FORWARD_EN=1: same STR, EXE not load -> no stall; EXE_MEM_R_EN=1 -> HazardOut=1 one cycle.
//  - ADDEQ with Z=0 -> bubble, validOut=0, WB_EN=0; with Z=1 -> decoded; flushIn=1 -> bubble always.
//  - WB writes R6=0xDEAD same cycle as decoding MOV R0,R6 (I=0): WB_BYPASS=1 -> Val_Rm=0xDEAD; 0 -> old R6.

Source files
------------

// File: rtl/id_stage_piped_pkg.sv
// Shared decode constants for the ARM decode stage:
// ALU command codes, instruction modes, opcodes and condition codes.
package id_stage_piped_pkg;

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_CMP = 4'b0100;
   localparam logic [3:0] CMD_TST = 4'b0110;
   localparam logic [3:0] CMD_LDR = 4'b0010;
   localparam logic [3:0] CMD_STR = 4'b0010;

   typedef enum logic [1:0] {
      MODE_DP  = 2'b00,
      MODE_MEM = 2'b01,
      MODE_BR  = 2'b10,
      MODE_RSV = 2'b11
   } mode_e;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_TST = 4'b1000;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_MVN = 4'b1111;

   localparam logic [3:0] COND_EQ = 4'd0;
   localparam logic [3:0] COND_NE = 4'd1;
   localparam logic [3:0] COND_CS = 4'd2;
   localparam logic [3:0] COND_CC = 4'd3;
   localparam logic [3:0] COND_MI = 4'd4;
   localparam logic [3:0] COND_PL = 4'd5;
   localparam logic [3:0] COND_VS = 4'd6;
   localparam logic [3:0] COND_VC = 4'd7;
   localparam logic [3:0] COND_HI = 4'd8;
   localparam logic [3:0] COND_LS = 4'd9;
   localparam logic [3:0] COND_GE = 4'd10;
   localparam logic [3:0] COND_LT = 4'd11;
   localparam logic [3:0] COND_GT = 4'd12;
   localparam logic [3:0] COND_LE = 4'd13;
   localparam logic [3:0] COND_AL = 4'd14;

   function automatic logic cond_pass(input logic [3:0] c,
                                      input logic [3:0] nzcv);
      logic n, z, cf, v, r;
      {n, z, cf, v} = nzcv;
      case (c)
         COND_EQ: r = z;
         COND_NE: r = ~z;
         COND_CS: r = cf;
         COND_CC: r = ~cf;
         COND_MI: r = n;
         COND_PL: r = ~n;
         COND_VS: r = v;
         COND_VC: r = ~v;
         COND_HI: r = cf & ~z;
         COND_LS: r = ~cf | z;
         COND_GE: r = (n == v);
         COND_LT: r = (n != v);
         COND_GT: r = ~z & (n == v);
         COND_LE: r = z | (n != v);
         COND_AL: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/id_stage_piped_regfile_bypass.sv
// 16-entry, 2-read/1-write register file with optional
// write-through so a same-cycle WB write is visible to readers.
module regfile_bypass #(
   parameter int N         = 32,
   parameter int WB_BYPASS = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_we,
   input  logic [3:0]   i_wa,
   input  logic [N-1:0] i_wd,
   input  logic [3:0]   i_ra1,
   input  logic [3:0]   i_ra2,
   output logic [N-1:0] o_rd1,
   output logic [N-1:0] o_rd2
);

   logic [N-1:0] r_mem [16];
   logic         w_hit1, w_hit2;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < 16; k++) r_mem[k] <= '0;
      end else if (i_we) begin
         r_mem[i_wa] <= i_wd;
      end
   end

   assign w_hit1 = (WB_BYPASS != 0) && i_we && (i_wa == i_ra1);
   assign w_hit2 = (WB_BYPASS != 0) && i_we && (i_wa == i_ra2);
   assign o_rd1  = w_hit1 ? i_wd : r_mem[i_ra1];
   assign o_rd2  = w_hit2 ? i_wd : r_mem[i_ra2];

endmodule

// File: rtl/id_stage_piped.sv
// ARM decode stage with built-in hazard detection, condition
// check and the ID/EX pipeline register (one cycle latency).
module id_stage_piped
   import id_stage_piped_pkg::*;
#(
   parameter int N          = 32,
   parameter int FORWARD_EN = 0,
   parameter int WB_BYPASS  = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] instructionIn,
   input  logic [N-1:0] PCIn,
   input  logic         validIn,
   input  logic [3:0]   statusIn,
   input  logic         flushIn,
   input  logic         WB_ENIn,
   input  logic [3:0]   WB_DestIn,
   input  logic [N-1:0] WB_ValueIn,
   input  logic         EXE_WB_ENIn,
   input  logic         EXE_MEM_R_ENIn,
   input  logic [3:0]   EXE_DestIn,
   input  logic         MEM_WB_ENIn,
   input  logic [3:0]   MEM_DestIn,
   output logic         HazardOut,
   output logic         validOut,
   output logic [N-1:0] PCOut,
   output logic [N-1:0] Val_RnOut,
   output logic [N-1:0] Val_RmOut,
   output logic [3:0]   SrcRnOut,
   output logic [3:0]   SrcRmOut,
   output logic [3:0]   DestOut,
   output logic [3:0]   EXE_CMDOut,
   output logic         SOut,
   output logic         BOut,
   output logic         MEM_W_ENOut,
   output logic         MEM_R_ENOut,
   output logic         WB_ENOut,
   output logic         IOut,
   output logic         Two_srcOut,
   output logic [11:0]  shiftOperandOut,
   output logic [23:0]  Imm24Out
);

   mode_e       w_mode;
   logic [3:0]  w_cond, w_op, w_rn, w_rd, w_rm, w_src2;
   logic        w_ibit, w_sbit, w_str, w_two, w_rn_used;
   logic [3:0]  w_cmd;
   logic        w_wb, w_mr, w_mw, w_b, w_s;
   logic        w_hit_rn, w_hit_s2, w_go;
   logic [N-1:0] w_val_rn, w_val_rm;

   assign w_cond = instructionIn[31:28];
   assign w_mode = mode_e'(instructionIn[27:26]);
   assign w_ibit = instructionIn[25];
   assign w_op   = instructionIn[24:21];
   assign w_sbit = instructionIn[20];
   assign w_rn   = instructionIn[19:16];
   assign w_rd   = instructionIn[15:12];
   assign w_rm   = instructionIn[3:0];

   assign w_str  = (w_mode == MODE_MEM) & ~w_sbit;
   assign w_two  = ~w_ibit | w_str;
   assign w_src2 = w_str ? w_rd : w_rm;
   assign w_rn_used = (w_mode != MODE_BR) &
      ~((w_mode == MODE_DP) & ((w_op == OP_MOV) | (w_op == OP_MVN)));

   always_comb begin
      w_cmd = '0;
      w_wb  = 1'b0;
      w_mr  = 1'b0;
      w_mw  = 1'b0;
      w_b   = 1'b0;
      w_s   = 1'b0;
      case (w_mode)
         MODE_DP: begin
            w_s  = w_sbit;
            w_wb = 1'b1;
            case (w_op)
               OP_MOV:  w_cmd = CMD_MOV;
               OP_MVN:  w_cmd = CMD_MVN;
               OP_ADD:  w_cmd = CMD_ADD;
               OP_ADC:  w_cmd = CMD_ADC;
               OP_SUB:  w_cmd = CMD_SUB;
               OP_SBC:  w_cmd = CMD_SBC;
               OP_AND:  w_cmd = CMD_AND;
               OP_ORR:  w_cmd = CMD_ORR;
               OP_EOR:  w_cmd = CMD_EOR;
               OP_CMP: begin w_cmd = CMD_CMP; w_wb = 1'b0; end
               OP_TST: begin w_cmd = CMD_TST; w_wb = 1'b0; end
               default: w_wb = 1'b0;
            endcase
         end
         MODE_MEM: begin
            w_cmd = w_sbit ? CMD_LDR : CMD_STR;
            w_mr  = w_sbit;
            w_wb  = w_sbit;
            w_mw  = ~w_sbit;
         end
         MODE_BR: w_b = 1'b1;
         default: ;
      endcase
   end

   // With forwarding only an EXE load cannot be bypassed in time.
   always_comb begin
      if (FORWARD_EN != 0) begin
         w_hit_rn = EXE_MEM_R_ENIn & EXE_WB_ENIn & (w_rn == EXE_DestIn);
         w_hit_s2 = EXE_MEM_R_ENIn & EXE_WB_ENIn & (w_src2 == EXE_DestIn);
      end else begin
         w_hit_rn = (EXE_WB_ENIn & (w_rn == EXE_DestIn)) |
                    (MEM_WB_ENIn & (w_rn == MEM_DestIn));
         w_hit_s2 = (EXE_WB_ENIn & (w_src2 == EXE_DestIn)) |
                    (MEM_WB_ENIn & (w_src2 == MEM_DestIn));
      end
   end

   assign HazardOut = validIn & ~flushIn &
      ((w_rn_used & w_hit_rn) | (w_two & w_hit_s2));

   assign w_go = validIn & ~flushIn & ~HazardOut &
      cond_pass(w_cond, statusIn);

   regfile_bypass #(.N(N), .WB_BYPASS(WB_BYPASS)) u_rf (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_we    (WB_ENIn),
      .i_wa    (WB_DestIn),
      .i_wd    (WB_ValueIn),
      .i_ra1   (w_rn),
      .i_ra2   (w_src2),
      .o_rd1   (w_val_rn),
      .o_rd2   (w_val_rm)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         validOut        <= 1'b0;
         PCOut           <= '0;
         Val_RnOut       <= '0;
         Val_RmOut       <= '0;
         SrcRnOut        <= '0;
         SrcRmOut        <= '0;
         DestOut         <= '0;
         EXE_CMDOut      <= '0;
         SOut            <= 1'b0;
         BOut            <= 1'b0;
         MEM_W_ENOut     <= 1'b0;
         MEM_R_ENOut     <= 1'b0;
         WB_ENOut        <= 1'b0;
         IOut            <= 1'b0;
         Two_srcOut      <= 1'b0;
         shiftOperandOut <= '0;
         Imm24Out        <= '0;
      end else begin
         validOut        <= w_go;
         PCOut           <= PCIn;
         Val_RnOut       <= w_val_rn;
         Val_RmOut       <= w_val_rm;
         SrcRnOut        <= w_rn;
         SrcRmOut        <= w_src2;
         DestOut         <= w_rd;
         EXE_CMDOut      <= w_go ? w_cmd : 4'd0;
         SOut            <= w_go & w_s;
         BOut            <= w_go & w_b;
         MEM_W_ENOut     <= w_go & w_mw;
         MEM_R_ENOut     <= w_go & w_mr;
         WB_ENOut        <= w_go & w_wb;
         IOut            <= w_ibit;
         Two_srcOut      <= w_two;
         shiftOperandOut <= instructionIn[11:0];
         Imm24Out        <= instructionIn[23:0];
      end
   end

endmodule
